// File: rtl/passcode_check_core_if.sv
// Bundle of the keypad entry-path signals between the encoder/entry
// registers (master) and the passcode check core (slave).
interface passcode_check_core_if #(
    parameter int CODE_W = 32
);
    logic              key_valid;
    logic              sel;
    logic [CODE_W-1:0] user_code;
    logic [CODE_W-1:0] set_code;
    logic              entry_done;
    logic [1:0]        mode_out;
    logic              match;
    logic [3:0]        attempt_count;
    logic              attempt_carry;

    modport master (
        output key_valid, sel, user_code, set_code, entry_done,
        input  mode_out, match, attempt_count, attempt_carry
    );

    modport slave (
        input  key_valid, sel, user_code, set_code, entry_done,
        output mode_out, match, attempt_count, attempt_carry
    );
endinterface

// File: rtl/passcode_check_core.sv
// Passcode check core: keypress strobe demux, bitwise code comparator and
// a single-digit BCD counter of completed user entry attempts.
module passcode_check_core #(
    parameter int CODE_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    passcode_check_core_if.slave bus
);
    logic              done_q;
    logic [3:0]        count_q;
    logic              carry_q;
    logic [CODE_W-1:0] code_diff;
    logic              inc;

    // Route the key strobe to the user or set-passcode entry channel.
    always_comb begin
        bus.mode_out    = '0;
        bus.mode_out[0] = bus.key_valid & ~bus.sel;
        bus.mode_out[1] = bus.key_valid &  bus.sel;
    end

    // Codes match only when every bit is equal; no BCD legality check.
    always_comb begin
        code_diff = bus.user_code ^ bus.set_code;
        bus.match = ~|code_diff;
    end

    // An attempt is counted on the rising edge of the entry_done level.
    always_comb begin
        inc = bus.entry_done & ~done_q;
    end

    // BCD attempt counter with one-cycle carry pulse on the 9 -> 0 wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q  <= 1'b0;
            count_q <= '0;
            carry_q <= 1'b0;
        end else begin
            done_q  <= bus.entry_done;
            carry_q <= 1'b0;
            if (inc) begin
                if (count_q == 4'd9) begin
                    count_q <= '0;
                    carry_q <= 1'b1;
                end else begin
                    count_q <= count_q + 4'd1;
                end
            end
        end
    end

    assign bus.attempt_count = count_q;
    assign bus.attempt_carry = carry_q;
endmodule

// File: tb/tb_passcode_check_core.sv
// Directed testbench for passcode_check_core.
module tb_passcode_check_core;
    logic clk;
    logic rst;
    int   vectors;
    int   errs;

    passcode_check_core_if #(.CODE_W(32)) bus ();

    passcode_check_core #(.CODE_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        bus.entry_done = 1'b1;
        tick();
        bus.entry_done = 1'b0;
        tick();
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        rst            = 1'b1;
        bus.key_valid  = 1'b0;
        bus.sel        = 1'b0;
        bus.user_code  = '0;
        bus.set_code   = '0;
        bus.entry_done = 1'b0;
        tick();
        tick();
        chk("reset_count", 32'(bus.attempt_count), 32'd0);
        chk("reset_carry", 32'(bus.attempt_carry), 32'd0);

        // Demux sweep (also while in reset: demux ignores rst)
        bus.key_valid = 1'b0; bus.sel = 1'b0; #1;
        chk("demux_kv0_s0", 32'(bus.mode_out), 32'b00);
        bus.key_valid = 1'b0; bus.sel = 1'b1; #1;
        chk("demux_kv0_s1", 32'(bus.mode_out), 32'b00);
        bus.key_valid = 1'b1; bus.sel = 1'b0; #1;
        chk("demux_kv1_s0", 32'(bus.mode_out), 32'b01);
        bus.key_valid = 1'b1; bus.sel = 1'b1; #1;
        chk("demux_kv1_s1", 32'(bus.mode_out), 32'b10);
        bus.key_valid = 1'b0; bus.sel = 1'b0;

        // Comparator
        bus.user_code = 32'h21935488; bus.set_code = 32'h21935488; #1;
        chk("cmp_equal", 32'(bus.match), 32'd1);
        bus.set_code = 32'h21935477; #1;
        chk("cmp_diff", 32'(bus.match), 32'd0);
        bus.set_code = 32'h21935488;
        for (int i = 0; i < 32; i++) begin
            bus.user_code = 32'h21935488 ^ (32'd1 << i); #1;
            chk($sformatf("cmp_walk_bit%0d", i), 32'(bus.match), 32'd0);
        end
        bus.user_code = 32'hFFFFFFFF; bus.set_code = 32'hFFFFFFFF; #1;
        chk("cmp_all_ones", 32'(bus.match), 32'd1);

        // Counter basic: 3-cycle high level counts once
        rst = 1'b0;
        bus.entry_done = 1'b1;
        tick();
        chk("basic_first_edge", 32'(bus.attempt_count), 32'd1);
        tick();
        tick();
        chk("basic_held", 32'(bus.attempt_count), 32'd1);
        bus.entry_done = 1'b0;
        tick();
        chk("basic_released", 32'(bus.attempt_count), 32'd1);
        pulse();
        pulse();
        chk("basic_three", 32'(bus.attempt_count), 32'd3);
        chk("basic_carry", 32'(bus.attempt_carry), 32'd0);

        // Counter wrap from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wrap_start", 32'(bus.attempt_count), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            bus.entry_done = 1'b1;
            tick();
            chk($sformatf("wrap_count_%0d", k), 32'(bus.attempt_count), 32'(k % 10));
            chk($sformatf("wrap_carry_%0d", k), 32'(bus.attempt_carry), (k == 10) ? 32'd1 : 32'd0);
            bus.entry_done = 1'b0;
            tick();
            chk($sformatf("wrap_carry_low_%0d", k), 32'(bus.attempt_carry), 32'd0);
        end
        pulse();
        chk("wrap_restart", 32'(bus.attempt_count), 32'd1);

        // Reset priority over a simultaneous rising edge
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) pulse();
        chk("prio_pre", 32'(bus.attempt_count), 32'd5);
        bus.entry_done = 1'b1;
        rst = 1'b1;
        tick();
        chk("prio_count", 32'(bus.attempt_count), 32'd0);
        chk("prio_carry", 32'(bus.attempt_carry), 32'd0);

        // entry_done held through reset counts once after release
        tick();
        chk("held_in_reset", 32'(bus.attempt_count), 32'd0);
        rst = 1'b0;
        tick();
        chk("held_first_edge", 32'(bus.attempt_count), 32'd1);
        tick();
        tick();
        tick();
        chk("held_stays", 32'(bus.attempt_count), 32'd1);
        bus.entry_done = 1'b0;
        tick();
        chk("held_release", 32'(bus.attempt_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/passcode_check_core.md
# passcode_check_core

Control and checking core for the keypad passcode entry path. It routes each encoded keypress strobe to either the user-input or the set-passcode (SP) entry channel, and compares the two 32-bit (8 BCD digit) code registers for equality. It also counts completed user entry attempts in a single BCD digit. It sits between the keypad encoder/entry shift-register arrays and the lock/status logic.

## Interface
Parameters:
- CODE_W, 32, width of each compared code vector (8 digits x 4 bits).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- key_valid  input  1  keypress-present strobe from the encoder (encoder bit 4).
- sel  input  1  entry channel select: 0 = user input, 1 = set passcode.
- user_code  input  CODE_W  user-entered code, digit 1 in bits [31:28].
- set_code  input  CODE_W  stored passcode, same digit ordering.
- entry_done  input  1  level, high when a user 8-digit entry has completed.
- mode_out  output  2  demuxed key strobe: [0] = user channel, [1] = SP channel.
- match  output  1  high when user_code == set_code.
- attempt_count  output  4  BCD attempt count, 0-9.
- attempt_carry  output  1  one-cycle pulse when the count wraps from 9 to 0.

## Operation
- Demux (combinational):
  - mode_out[0] = key_valid & ~sel.
  - mode_out[1] = key_valid & sel.
  - At most one bit is ever high. Both bits are 0 when key_valid = 0.
  - Reset does not affect the demux.
- Comparator (combinational):
  - match = 1 if and only if all CODE_W bits are equal. Any single-bit difference gives 0.
  - Input values are not checked for BCD legality; the comparison is purely bitwise.
  - Reset does not affect the comparator.
- Attempt counter (sequential):
  - Register done_q holds entry_done delayed by one clock.
  - Increment condition: entry_done & ~done_q, i.e. a rising edge of entry_done.
  - On increment, attempt_count goes to attempt_count + 1, except 9 goes to 0.
  - On the 9 -> 0 step, attempt_carry = 1 for exactly that cycle; otherwise attempt_carry = 0.
  - Holding entry_done high counts once. Each later low-to-high transition counts again.
  - attempt_count only ever takes values 0-9. Codes 10-15 are unreachable.

## Timing
- Reset values: attempt_count = 0, attempt_carry = 0, done_q = 0.
- rst has priority over the increment condition in the same cycle.
- Because done_q resets to 0, an entry_done that is already high when rst deasserts counts once, at the first clock edge after reset.
- Increment latency:
  - attempt_count changes at the same rising edge at which the rising edge of entry_done is sampled.
  - That new value is visible for the following cycle.
- attempt_carry is asserted in the cycle after the wrapping edge and is cleared at the next edge.
- mode_out and match have zero-cycle (combinational) latency from their inputs. They have no reset value.
- Reset asserted mid-count: attempt_count = 0 at the next edge, regardless of entry_done.

## Test plan
- Demux:
  - Sweep sel and key_valid through all four combinations.
  - Required: mode_out = 00 for key_valid = 0; 01 for key_valid = 1, sel = 0; 10 for key_valid = 1, sel = 1.
- Comparator:
  - user_code = set_code = 32'h21935488 -> match = 1.
  - Change set_code to 32'h21935477 -> match = 0.
  - Walk a single-bit difference across all 32 bit positions -> match = 0 each time.
- Counter basic:
  - After reset, pulse entry_done high for 3 cycles, then low. Required: attempt_count = 1, not 3.
  - Two further separate pulses -> attempt_count = 3.
- Counter wrap:
  - Apply 10 separate entry_done pulses from reset.
  - Required: count goes 1, 2, ... 9, 0. attempt_carry is high for exactly one cycle, at the 9 -> 0 step only.
- Reset priority:
  - With attempt_count = 5, assert rst in the same cycle as a rising edge of entry_done.
  - Required: attempt_count = 0 and attempt_carry = 0.
- Reset with entry_done held high:
  - Hold entry_done = 1 through reset, then release rst.
  - Required: attempt_count = 1 after the first post-reset edge, and it stays 1 while entry_done remains high.
